// File: rtl/corral_game_seq.sv
// Corral game engine: a cowboy chases NUM_HORSES LFSR-driven horses, then every position is reported serially.
// Define CORRAL_FENCE_EN for a fenced board where positions saturate at the edges instead of wrapping.
module corral_game_seq #(
  parameter int         POS_W      = 4,
  parameter int         NUM_HORSES = 2,
  parameter int         MAX_TURNS  = 15,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enter,
  input  logic [2:0]       move,
  output logic [POS_W-1:0] data,
  output logic [2:0]       data_idx,
  output logic             data_cap,
  output logic             data_valid,
  output logic             gameover,
  output logic             lostwon,
  output logic             ready
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] COWBOY = 3'd2;
  localparam logic [2:0] HORSE  = 3'd3;
  localparam logic [2:0] GAME   = 3'd4;
  localparam logic [2:0] REPORT = 3'd5;

  localparam int         MAX_POS    = (1 << POS_W) - 1;
  localparam logic [3:0] LAST_HORSE = 4'(NUM_HORSES - 1);
  localparam logic [3:0] REPORT_END = 4'(NUM_HORSES + 1);
  localparam logic [7:0] TURN_LIMIT = 8'(MAX_TURNS);

  function automatic logic [POS_W-1:0] start_pos(input int k);
    return POS_W'(((k + 1) * (MAX_POS + 1)) / (NUM_HORSES + 1));
  endfunction

  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] pos,
                                                input logic             back,
                                                input logic [1:0]       step);
`ifdef CORRAL_FENCE_EN
    int t;
    t = back ? int'(pos) - int'(step) : int'(pos) + int'(step);
    if (t < 0) t = 0;
    else if (t > MAX_POS) t = MAX_POS;
    return POS_W'(t);
`else
    return back ? pos - POS_W'(step) : pos + POS_W'(step);
`endif
  endfunction

  logic [2:0]       state;
  logic [POS_W-1:0] cowboy;
  logic [POS_W-1:0] horse [NUM_HORSES];
  logic [NUM_HORSES-1:0] captured;
  logic [7:0]       turns;
  logic [7:0]       lfsr;
  logic             mv_back;
  logic [1:0]       mv_step;
  logic [3:0]       idx;

  logic [POS_W-1:0] cur_horse;
  logic             cur_cap;
  logic [POS_W-1:0] candidate;
  logic [POS_W-1:0] rep_pos;
  logic             rep_cap;
  logic [7:0]       turns_next;
  logic [7:0]       lfsr_next;

  // idx selects the horse being stepped in HORSE and the report slot (0 = cowboy) elsewhere
  always_comb begin
    cur_horse = '0;
    cur_cap   = 1'b0;
    rep_pos   = cowboy;
    rep_cap   = 1'b0;
    for (int k = 0; k < NUM_HORSES; k++) begin
      if (idx == 4'(k)) begin
        cur_horse = horse[k];
        cur_cap   = captured[k];
      end
      if (idx == 4'(k + 1)) begin
        rep_pos = horse[k];
        rep_cap = captured[k];
      end
    end
    candidate  = step_pos(cur_horse, lfsr[2], lfsr[1:0]);
    turns_next = (turns == 8'hFF) ? turns : turns + 8'd1;
    lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      data       <= '0;
      data_idx   <= '0;
      data_cap   <= 1'b0;
      data_valid <= 1'b0;
      gameover   <= 1'b1;
      lostwon    <= 1'b0;
      ready      <= 1'b1;
      cowboy     <= '0;
      for (int k = 0; k < NUM_HORSES; k++) horse[k] <= start_pos(k);
      captured   <= '0;
      turns      <= '0;
      lfsr       <= LFSR_SEED;
      mv_back    <= 1'b0;
      mv_step    <= 2'd0;
      idx        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enter) begin
            ready <= 1'b0;
            idx   <= '0;
            if (gameover) begin
              cowboy <= '0;
              for (int k = 0; k < NUM_HORSES; k++) horse[k] <= start_pos(k);
              captured <= '0;
              turns    <= '0;
              gameover <= 1'b0;
              lostwon  <= 1'b0;
              state    <= START;
            end else begin
              mv_back <= move[2];
              mv_step <= move[1:0];
              state   <= COWBOY;
            end
          end
        end
        START: begin
          data_valid <= 1'b1;
          data       <= rep_pos;
          data_idx   <= idx[2:0];
          data_cap   <= rep_cap;
          idx        <= 4'd1;
          state      <= REPORT;
        end
        COWBOY: begin
          cowboy <= step_pos(cowboy, mv_back, mv_step);
          state  <= HORSE;
        end
        // A horse already on the cowboy's cell is caught before it gets to move
        HORSE: begin
          for (int k = 0; k < NUM_HORSES; k++) begin
            if (idx == 4'(k) && !cur_cap) begin
              if (cur_horse == cowboy) captured[k] <= 1'b1;
              else if (candidate != cowboy) horse[k] <= candidate;
            end
          end
          lfsr <= lfsr_next;
          if (idx == LAST_HORSE) begin
            idx   <= '0;
            state <= GAME;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        GAME: begin
          turns <= turns_next;
          if (&captured) begin
            gameover <= 1'b1;
            lostwon  <= 1'b1;
          end else if (turns_next == TURN_LIMIT) begin
            gameover <= 1'b1;
            lostwon  <= 1'b0;
          end
          data_valid <= 1'b1;
          data       <= rep_pos;
          data_idx   <= idx[2:0];
          data_cap   <= rep_cap;
          idx        <= 4'd1;
          state      <= REPORT;
        end
        REPORT: begin
          if (idx == REPORT_END) begin
            data_valid <= 1'b0;
            data_idx   <= '0;
            data_cap   <= 1'b0;
            ready      <= 1'b1;
            idx        <= '0;
            state      <= IDLE;
          end else begin
            data       <= rep_pos;
            data_idx   <= idx[2:0];
            data_cap   <= rep_cap;
            idx        <= idx + 4'd1;
          end
        end
        default: begin
          data_valid <= 1'b0;
          ready      <= 1'b1;
          idx        <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_corral_game_seq.sv
// Directed bench for corral_game_seq: three instances (default, MAX_TURNS=3, 2-bit board with one horse).
// Expected horse moves come from hand-stepping the LFSR from seed 8'hA5.
module tb_corral_game_seq;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;

  logic       enter_a, enter_b, enter_c;
  logic [2:0] move_a, move_b, move_c;
  logic [3:0] data_a, data_b;
  logic [1:0] data_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic       cap_a, cap_b, cap_c;
  logic       valid_a, valid_b, valid_c;
  logic       go_a, go_b, go_c;
  logic       lw_a, lw_b, lw_c;
  logic       rdy_a, rdy_b, rdy_c;

  corral_game_seq dut_a (
    .clock(clock), .reset_n(reset_n), .enter(enter_a), .move(move_a),
    .data(data_a), .data_idx(idx_a), .data_cap(cap_a), .data_valid(valid_a),
    .gameover(go_a), .lostwon(lw_a), .ready(rdy_a)
  );

  corral_game_seq #(.MAX_TURNS(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .enter(enter_b), .move(move_b),
    .data(data_b), .data_idx(idx_b), .data_cap(cap_b), .data_valid(valid_b),
    .gameover(go_b), .lostwon(lw_b), .ready(rdy_b)
  );

  corral_game_seq #(.POS_W(2), .NUM_HORSES(1)) dut_c (
    .clock(clock), .reset_n(reset_n), .enter(enter_c), .move(move_c),
    .data(data_c), .data_idx(idx_c), .data_cap(cap_c), .data_valid(valid_c),
    .gameover(go_c), .lostwon(lw_c), .ready(rdy_c)
  );

  int checks = 0;
  int fails  = 0;

  logic [3:0] rep_data [8];
  logic       rep_cap  [8];
  int         rep_cnt;
  int         lat;
  logic       rep_order_ok;

  typedef struct {
    logic [2:0] mv;
    int         lat;
    logic [3:0] d0, d1, d2;
    logic       c1, c2;
    logic       go, lw;
  } vec_t;

  vec_t vecs [3];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sample(input int sel, output logic [3:0] d, output logic [2:0] i, output logic c,
                        output logic v, output logic g, output logic l, output logic r);
    case (sel)
      0: begin d = data_a; i = idx_a; c = cap_a; v = valid_a; g = go_a; l = lw_a; r = rdy_a; end
      1: begin d = data_b; i = idx_b; c = cap_b; v = valid_b; g = go_b; l = lw_b; r = rdy_b; end
      default: begin d = {2'b00, data_c}; i = idx_c; c = cap_c; v = valid_c; g = go_c; l = lw_c; r = rdy_c; end
    endcase
  endtask

  task automatic set_enter(input int sel, input logic e, input logic [2:0] mv);
    case (sel)
      0: begin enter_a = e; move_a = mv; end
      1: begin enter_b = e; move_b = mv; end
      default: begin enter_c = e; move_c = mv; end
    endcase
  endtask

  // One enter pulse, then collect the report and the cycle count until ready returns
  task automatic apply_stimulus(input int sel, input logic [2:0] mv, input string tag);
    logic [3:0] d;
    logic [2:0] i;
    logic       c, v, g, l, r;
    rep_cnt = 0;
    rep_order_ok = 1'b1;
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      rep_data[k] = '0;
      rep_cap[k]  = 1'b0;
    end
    @(negedge clock);
    set_enter(sel, 1'b1, mv);
    @(posedge clock);
    #1;
    set_enter(sel, 1'b0, 3'b000);
    sample(sel, d, i, c, v, g, l, r);
    check_output({tag, "_ready_drop"}, 32'(r), 32'd0);
    while (lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
      sample(sel, d, i, c, v, g, l, r);
      if (v) begin
        if (32'(i) != 32'(rep_cnt)) rep_order_ok = 1'b0;
        if (rep_cnt < 8) begin
          rep_data[rep_cnt] = d;
          rep_cap[rep_cnt]  = c;
        end
        rep_cnt++;
      end
      if (r) break;
    end
  endtask

  initial begin
    logic [3:0] d, d0;
    logic [2:0] i, i0;
    logic       c, v, g, l, r, c0, v0, g0, l0, r0;
    logic       changed;
    int         n;

    reset_n = 1'b0;
    enter_a = 1'b0; enter_b = 1'b0; enter_c = 1'b0;
    move_a = 3'b000; move_b = 3'b000; move_c = 3'b000;

`ifdef CORRAL_FENCE_EN
    vecs[0] = '{mv: 3'b000, lat: 4, d0: 4'd0,  d1: 4'd5, d2: 4'd10, c1: 1'b0, c2: 1'b0, go: 1'b0, lw: 1'b0};
    vecs[1] = '{mv: 3'b111, lat: 7, d0: 4'd0,  d1: 4'd4, d2: 4'd12, c1: 1'b0, c2: 1'b0, go: 1'b0, lw: 1'b0};
    vecs[2] = '{mv: 3'b001, lat: 7, d0: 4'd1,  d1: 4'd3, d2: 4'd14, c1: 1'b0, c2: 1'b0, go: 1'b0, lw: 1'b0};
`else
    vecs[0] = '{mv: 3'b000, lat: 4, d0: 4'd0,  d1: 4'd5, d2: 4'd10, c1: 1'b0, c2: 1'b0, go: 1'b0, lw: 1'b0};
    vecs[1] = '{mv: 3'b111, lat: 7, d0: 4'd13, d1: 4'd4, d2: 4'd12, c1: 1'b0, c2: 1'b0, go: 1'b0, lw: 1'b0};
    vecs[2] = '{mv: 3'b001, lat: 7, d0: 4'd14, d1: 4'd3, d2: 4'd12, c1: 1'b0, c2: 1'b0, go: 1'b0, lw: 1'b0};
`endif

    #12;
    sample(0, d, i, c, v, g, l, r);
    check_output("rst_gameover", 32'(g), 32'd1);
    check_output("rst_lostwon", 32'(l), 32'd0);
    check_output("rst_ready", 32'(r), 32'd1);
    check_output("rst_valid", 32'(v), 32'd0);
    check_output("rst_data", 32'(d), 32'd0);
    check_output("rst_idx", 32'(i), 32'd0);
    check_output("rst_cap", 32'(c), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    sample(0, d0, i0, c0, v0, g0, l0, r0);
    changed = 1'b0;
    repeat (20) begin
      @(negedge clock);
      sample(0, d, i, c, v, g, l, r);
      if ({d, i, c, v, g, l, r} != {d0, i0, c0, v0, g0, l0, r0}) changed = 1'b1;
    end
    check_output("idle_stable", 32'(changed), 32'd0);

    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0, vecs[k].mv, $sformatf("a%0d", k));
      sample(0, d, i, c, v, g, l, r);
      check_output($sformatf("a%0d_latency", k), 32'(lat), 32'(vecs[k].lat));
      check_output($sformatf("a%0d_rep_count", k), 32'(rep_cnt), 32'd3);
      check_output($sformatf("a%0d_rep_order", k), 32'(rep_order_ok), 32'd1);
      check_output($sformatf("a%0d_cowboy", k), 32'(rep_data[0]), 32'(vecs[k].d0));
      check_output($sformatf("a%0d_cowboy_cap", k), 32'(rep_cap[0]), 32'd0);
      check_output($sformatf("a%0d_horse0", k), 32'(rep_data[1]), 32'(vecs[k].d1));
      check_output($sformatf("a%0d_horse1", k), 32'(rep_data[2]), 32'(vecs[k].d2));
      check_output($sformatf("a%0d_cap0", k), 32'(rep_cap[1]), 32'(vecs[k].c1));
      check_output($sformatf("a%0d_cap1", k), 32'(rep_cap[2]), 32'(vecs[k].c2));
      check_output($sformatf("a%0d_gameover", k), 32'(g), 32'(vecs[k].go));
      check_output($sformatf("a%0d_lostwon", k), 32'(l), 32'(vecs[k].lw));
      check_output($sformatf("a%0d_valid_off", k), 32'(v), 32'd0);
    end

    // Turn limit: cowboy parks on cell 0, horses can never land there
    apply_stimulus(1, 3'b000, "b_start");
    check_output("b_start_latency", 32'(lat), 32'd4);
    for (int t = 1; t <= 3; t++) begin
      apply_stimulus(1, 3'b000, $sformatf("b_turn%0d", t));
      sample(1, d, i, c, v, g, l, r);
      check_output($sformatf("b_turn%0d_latency", t), 32'(lat), 32'd7);
      check_output($sformatf("b_turn%0d_cowboy", t), 32'(rep_data[0]), 32'd0);
      check_output($sformatf("b_turn%0d_caps", t), 32'({rep_cap[1], rep_cap[2]}), 32'd0);
      check_output($sformatf("b_turn%0d_horses_off0", t),
                   32'(rep_data[1] != 4'd0 && rep_data[2] != 4'd0), 32'd1);
      check_output($sformatf("b_turn%0d_gameover", t), 32'(g), (t == 3) ? 32'd1 : 32'd0);
      check_output($sformatf("b_turn%0d_lostwon", t), 32'(l), 32'd0);
    end

    apply_stimulus(2, 3'b000, "c_start");
    check_output("c_start_latency", 32'(lat), 32'd3);
    check_output("c_start_count", 32'(rep_cnt), 32'd2);
    check_output("c_start_horse", 32'(rep_data[1]), 32'd2);
    check_output("c_start_cap", 32'(rep_cap[1]), 32'd0);
    apply_stimulus(2, 3'b010, "c_move");
    sample(2, d, i, c, v, g, l, r);
    check_output("c_move_latency", 32'(lat), 32'd5);
    check_output("c_move_order", 32'(rep_order_ok), 32'd1);
    check_output("c_move_cowboy", 32'(rep_data[0]), 32'd2);
    check_output("c_move_horse", 32'(rep_data[1]), 32'd2);
    check_output("c_move_cap", 32'(rep_cap[1]), 32'd1);
    check_output("c_move_gameover", 32'(g), 32'd1);
    check_output("c_move_lostwon", 32'(l), 32'd1);

    // enter pulsed while the report is streaming must not start another turn
    @(negedge clock);
    enter_a = 1'b1;
    move_a = 3'b000;
    @(posedge clock);
    #1;
    enter_a = 1'b0;
    n = 0;
    while (!valid_a && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_output("ign_report_seen", 32'(valid_a), 32'd1);
    enter_a = 1'b1;
    @(posedge clock);
    #1;
    enter_a = 1'b0;
    n = 0;
    while (!rdy_a && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_output("ign_ready_back", 32'(rdy_a), 32'd1);
    changed = 1'b0;
    repeat (6) begin
      @(posedge clock);
      #1;
      if (!rdy_a || valid_a) changed = 1'b1;
    end
    check_output("ign_no_extra_turn", 32'(changed), 32'd0);

    // Reset dropped mid-report must clear outputs without a clock edge
    @(negedge clock);
    enter_a = 1'b1;
    @(posedge clock);
    #1;
    enter_a = 1'b0;
    n = 0;
    while (!valid_a && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_output("arst_report_seen", 32'(valid_a), 32'd1);
    check_output("arst_game_running", 32'(go_a), 32'd0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_output("arst_valid", 32'(valid_a), 32'd0);
    check_output("arst_gameover", 32'(go_a), 32'd1);
    check_output("arst_ready", 32'(rdy_a), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
